// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: time/alarm compare inputs, buttons and alarm outputs
// master drives en, time_in, alarm_in, stop, snooze; slave drives buzzer, ringing, snoozing, snooze_left
interface alarm_trigger_if;
  logic        en;
  logic [31:0] time_in;
  logic [31:0] alarm_in;
  logic        stop;
  logic        snooze;
  logic        buzzer;
  logic        ringing;
  logic        snoozing;
  logic [1:0]  snooze_left;
  modport master (
    output en, time_in, alarm_in, stop, snooze,
    input  buzzer, ringing, snoozing, snooze_left
  );
  modport slave (
    input  en, time_in, alarm_in, stop, snooze,
    output buzzer, ringing, snoozing, snooze_left
  );
endinterface

// File: rtl/alarm_trigger.sv
// alarm_trigger: rings a gated 500 Hz buzzer when the clock time reaches the alarm time
// clk_1khz/rst: 1 kHz clock, sync active-high reset
// bus.en arms the alarm; bus.time_in/alarm_in packed nibble times; bus.stop/snooze level buttons
// bus.buzzer tone, bus.ringing/snoozing state flags, bus.snooze_left snoozes remaining
module alarm_trigger #(
  parameter int RING_MS     = 60000,
  parameter int SNOOZE_MS   = 300000,
  parameter int BEEP_PERIOD = 500,
  parameter int MAX_SNOOZE  = 3
) (
  input logic clk_1khz,
  input logic rst,
  alarm_trigger_if.slave bus
);
  localparam int RW = $clog2(RING_MS);
  localparam int SW = $clog2(SNOOZE_MS);
  localparam int BW = $clog2(BEEP_PERIOD);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic [1:0] snooze_left_q, snooze_left_d;
  logic tone_q, tone_d;
  logic match, match_q, stop_q, snooze_q;
  logic trigger, stop_p, snooze_p;
  logic buzzer_q, buzzer_d, ringing_q, ringing_d, snoozing_q, snoozing_d;
  logic unused;
  // separator nibbles carry no time information
  assign match = (bus.time_in[31:24] == bus.alarm_in[31:24]) &
                 (bus.time_in[19:12] == bus.alarm_in[19:12]) &
                 (bus.time_in[7:0]   == bus.alarm_in[7:0]);
  assign unused = ^{bus.time_in[23:20], bus.time_in[11:8], bus.alarm_in[23:20], bus.alarm_in[11:8]};
  assign trigger  = match & ~match_q;
  assign stop_p   = bus.stop & ~stop_q;
  assign snooze_p = bus.snooze & ~snooze_q;
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q       <= IDLE;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      beep_cnt_q    <= '0;
      snooze_left_q <= 2'(MAX_SNOOZE);
      tone_q        <= 1'b0;
      match_q       <= 1'b0;
      stop_q        <= 1'b0;
      snooze_q      <= 1'b0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      beep_cnt_q    <= beep_cnt_d;
      snooze_left_q <= snooze_left_d;
      tone_q        <= tone_d;
      match_q       <= match;
      stop_q        <= bus.stop;
      snooze_q      <= bus.snooze;
      buzzer_q      <= buzzer_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
    end
  end
  // tone starts high on every entry into RING so each ring phase begins with an audible gate
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    beep_cnt_d    = beep_cnt_q;
    snooze_left_d = snooze_left_q;
    tone_d        = tone_q;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (trigger) begin
          state_d       = RING;
          ring_cnt_d    = '0;
          beep_cnt_d    = '0;
          tone_d        = 1'b1;
          snooze_left_d = 2'(MAX_SNOOZE);
        end
        RING: if (stop_p) begin
          state_d = IDLE;
        end else if (snooze_p && snooze_left_q != 2'd0) begin
          state_d       = SNOOZE;
          snooze_left_d = snooze_left_q - 2'd1;
          snz_cnt_d     = '0;
        end else if (ring_cnt_q == RW'(RING_MS - 1)) begin
          state_d = IDLE;
        end else begin
          ring_cnt_d = ring_cnt_q + 1'b1;
          beep_cnt_d = beep_cnt_q == BW'(BEEP_PERIOD - 1) ? '0 : beep_cnt_q + 1'b1;
          tone_d     = ~tone_q;
        end
        SNOOZE: if (stop_p) begin
          state_d = IDLE;
        end else if (snz_cnt_q == SW'(SNOOZE_MS - 1)) begin
          state_d    = RING;
          ring_cnt_d = '0;
          beep_cnt_d = '0;
          tone_d     = 1'b1;
        end else begin
          snz_cnt_d = snz_cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs are decoded from the next state so they register on the same edge as the state
  always_comb begin
    ringing_d  = state_d == RING;
    snoozing_d = state_d == SNOOZE;
    buzzer_d   = ringing_d & tone_d & (beep_cnt_d < BW'(BEEP_PERIOD / 2));
  end
  assign bus.buzzer      = buzzer_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_left = snooze_left_q;
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: scoreboard bench comparing alarm_trigger against a behavioural model
module tb_alarm_trigger;
  localparam int RING_MS = 20;
  localparam int SNOOZE_MS = 30;
  localparam int BP = 8;
  localparam int MAXS = 2;
  localparam logic [31:0] ALARM = 32'h12E30E00;
  typedef struct packed {
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] left;
  } obs_t;
  logic clk = 1'b0;
  logic rst;
  alarm_trigger_if bus();
  alarm_trigger #(.RING_MS(RING_MS), .SNOOZE_MS(SNOOZE_MS), .BEEP_PERIOD(BP), .MAX_SNOOZE(MAXS))
    dut (.clk_1khz(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  obs_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  // model: mode 0 idle, 1 ringing, 2 snoozing; age = cycles spent in the current ring phase
  int mode = 0, age = 0, sage = 0, left = MAXS;
  bit prev_m = 0, prev_st = 0, prev_sn = 0;
  function automatic bit same_time(logic [31:0] t, logic [31:0] a);
    return t[31:28] == a[31:28] && t[27:24] == a[27:24] && t[19:16] == a[19:16] &&
           t[15:12] == a[15:12] && t[7:4] == a[7:4] && t[3:0] == a[3:0];
  endfunction
  task automatic model_step();
    bit m, trig, stp, snp;
    obs_t e;
    m = same_time(bus.time_in, bus.alarm_in);
    if (rst) begin
      mode = 0; left = MAXS; age = 0; sage = 0;
      prev_m = 0; prev_st = 0; prev_sn = 0;
    end else begin
      trig = m && !prev_m;
      stp = bus.stop && !prev_st;
      snp = bus.snooze && !prev_sn;
      prev_m = m; prev_st = bus.stop; prev_sn = bus.snooze;
      if (!bus.en) mode = 0;
      else if (mode == 0) begin
        if (trig) begin mode = 1; age = 0; left = MAXS; end
      end else if (mode == 1) begin
        if (stp) mode = 0;
        else if (snp && left > 0) begin mode = 2; left--; sage = 0; end
        else if (age == RING_MS - 1) mode = 0;
        else age++;
      end else begin
        if (stp) mode = 0;
        else if (sage == SNOOZE_MS - 1) begin mode = 1; age = 0; end
        else sage++;
      end
    end
    e.ringing = mode == 1;
    e.snoozing = mode == 2;
    e.buzzer = mode == 1 && age % 2 == 0 && age % BP < BP / 2;
    e.left = 2'(left);
    exp_q.push_back(e);
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    obs_t a, e;
    @(posedge clk);
    #1;
    a = '{bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_left};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty t=%0t got=%b", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs t=%0t got buz=%b ring=%b snz=%b left=%0d want buz=%b ring=%b snz=%b left=%0d",
                 $time, a.buzzer, a.ringing, a.snoozing, a.left, e.buzzer, e.ringing, e.snoozing, e.left);
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_snooze();
    bus.snooze = 1'b1; cyc(1); bus.snooze = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
  endtask
  task automatic arm_match();
    bus.time_in = 32'h12E29E59; cyc(2);
    bus.time_in = ALARM;
  endtask
  initial begin
    int r;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.time_in = 32'h0;
    bus.alarm_in = ALARM;
    bus.stop = 1'b0;
    bus.snooze = 1'b0;
    cyc(3);
    rst = 1'b0;
    bus.en = 1'b1;
    arm_match(); cyc(25);
    cyc(1000);
    bus.time_in = 32'h12E30E01; cyc(5);
    arm_match(); cyc(3);
    pulse_snooze(); cyc(34);
    pulse_snooze(); cyc(34);
    pulse_snooze(); cyc(25);
    arm_match(); cyc(3);
    bus.stop = 1'b1; bus.snooze = 1'b1; cyc(1);
    bus.stop = 1'b0; bus.snooze = 1'b0; cyc(5);
    bus.time_in = 32'h0; cyc(2);
    bus.time_in = 32'h12F30F00; cyc(4);
    pulse_stop(); cyc(3);
    arm_match(); cyc(4);
    rst = 1'b1; bus.time_in = 32'h0; cyc(1);
    rst = 1'b0; cyc(5);
    arm_match(); cyc(3);
    pulse_snooze(); cyc(5);
    bus.en = 1'b0; cyc(3);
    bus.en = 1'b1; cyc(40);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      bus.time_in = r < 4 ? ALARM : r < 6 ? 32'h12F30F00 : r < 8 ? 32'h12E30E01 : $urandom;
      bus.stop = $urandom_range(0, 29) == 0;
      bus.snooze = $urandom_range(0, 7) == 0;
      bus.en = $urandom_range(0, 99) != 0;
      rst = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
